warp_mem_sequencer: RTL and testbench
=====================================

# warp_mem_sequencer

Serializes one warp-wide memory operation (load or store, one address per thread) from the SIMT core onto a single-port memory interface. The block issues active threads in ascending thread order, collects load data per thread, and returns the gathered result to the core in a single response pulse. It sits between the core's per-thread memory outputs and the shared data memory. It replaces the assumption of per-thread combinational memory ports.

## Interface
- NUM_THREADS, 4, warp size (threads per request)
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 16, memory address width

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a warp memory request
- req_ready  out  1  sequencer idle; request accepted on req_valid && req_ready at a clk edge
- req_we  in  1  1 = store, 0 = load (whole warp)
- req_mask  in  NUM_THREADS  active-thread mask
- req_addr  in  [NUM_THREADS] x ADDR_WIDTH  per-thread address
- req_wdata  in  [NUM_THREADS] x DATA_WIDTH  per-thread store data
- rsp_valid  out  1  one-cycle pulse; request complete
- rsp_mask  out  NUM_THREADS  copy of the accepted req_mask
- rsp_rdata  out  [NUM_THREADS] x DATA_WIDTH  gathered load data (0 for inactive threads and for stores)
- mem_valid  out  1  memory access request
- mem_ready  in  1  memory accepts the access on mem_valid && mem_ready
- mem_we  out  1  access is a write
- mem_addr  out  ADDR_WIDTH  access address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rvalid  in  1  read data valid (one-cycle strobe)
- mem_rdata  in  DATA_WIDTH  read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_R, RESP.
- IDLE: req_ready=1. On accept: latch we, mask, addr[], wdata[]; set pending=mask; clear rdata[] to 0; clear reuse flag. Next state is RESP if mask==0, else ISSUE.
- ISSUE: cur = lowest-index set bit of pending.
  - Load with reuse flag set and addr[cur]==last_addr: rdata[cur]<=last_data, clear pending[cur]. No mem access. Takes 1 cycle.
  - Otherwise drive mem_valid=1, mem_we=we, mem_addr=addr[cur], mem_wdata=wdata[cur].
  - On mem_ready, a store clears pending[cur]. A load goes to WAIT_R.
  - When pending becomes 0, next state is RESP.
- WAIT_R: mem_valid=0. On mem_rvalid: rdata[cur]<=mem_rdata, last_addr<=addr[cur], last_data<=mem_rdata, set reuse flag, clear pending[cur]. Next state is RESP if pending is now empty, else ISSUE.
- RESP: rsp_valid=1 for exactly one cycle with rsp_mask and rsp_rdata. There is no backpressure. Next state is IDLE.
- Reuse is only compared against the most recent completed read of the current request. Stores never reuse and never merge. Duplicate store addresses are all written in thread order, so the highest thread wins.
- mem_rvalid outside WAIT_R is ignored. mem_ready is ignored when mem_valid=0.

## Timing
- Reset (async, immediate): state=IDLE, req_ready=1, busy=0, rsp_valid=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_mask=0, rsp_rdata all 0, pending=0, reuse flag=0. Reset mid-operation abandons the request: no rsp_valid, and a pending mem_rvalid is dropped.
- mem_valid, mem_we, mem_addr and mem_wdata stay stable from assertion until the mem_ready handshake.
- Store, mem_ready tied high: 1 thread per cycle. rsp_valid is high in cycle N+1 after the accept edge, where N = popcount(mask).
- Load, mem_ready high, rvalid k cycles after handshake (k>=1): each issued thread costs 1+k cycles. Each reused thread costs 1 cycle.
- mask==0: rsp_valid in the cycle after accept, with no memory traffic.
- req_ready=0 from the cycle after accept through the RESP cycle. A new request can be accepted in the cycle after RESP.
- rsp_rdata/rsp_mask hold their values after RESP until the next accept.

## Test plan
- Store, mask=4'b1011, addr={0x10,0x11,0x12,0x13}, wdata={0xA,0xB,0xC,0xD}, mem_ready=1 → writes (0x10,0xA),(0x11,0xB),(0x13,0xD) on consecutive cycles; rsp_valid in cycle 4 after accept; rsp_rdata all 0.
- Load, mask=4'b1111, distinct addrs, memory returns addr+0x100 with k=1 → 4 reads; rsp_rdata[t]=addr[t]+0x100; rsp_valid in cycle 9 after accept.
- Load, mask=4'b1111, addrs={0x20,0x20,0x20,0x30} → only 2 memory reads; rsp_rdata[0..2] are equal; total 2*2+2 cycles to RESP.
- Load, mask=4'b0100, mem_ready low for 3 cycles → mem_valid and mem_addr held stable for 4 cycles; only thread 2 has data; rsp_mask=4'b0100; other rdata are 0.
- mask=0 → no mem_valid; rsp_valid in cycle after accept. Then a back-to-back request is accepted in the cycle after RESP.
- rst asserted while in WAIT_R → all outputs at reset values immediately; late mem_rvalid ignored; no rsp_valid; the next request completes correctly.

Source files
------------

// File: rtl/warp_mem_sequencer.sv
// Serializes one warp-wide load/store onto a single-port memory, issuing active
// threads lowest-index first and returning the gathered result in one pulse.
module warp_mem_sequencer #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [NUM_THREADS-1:0]            req_mask,
  input  logic [NUM_THREADS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] req_wdata,
  output logic                              rsp_valid,
  output logic [NUM_THREADS-1:0]            rsp_mask,
  output logic [NUM_THREADS*DATA_WIDTH-1:0] rsp_rdata,
  output logic                              mem_valid,
  input  logic                              mem_ready,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_rvalid,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy
);

  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

  state_t                                 state_q, state_d;
  logic                                   we_q, we_d;
  logic [NUM_THREADS-1:0]                 mask_q, mask_d;
  logic [NUM_THREADS-1:0]                 pending_q, pending_d;
  logic [NUM_THREADS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                                   reuse_q, reuse_d;
  logic [ADDR_WIDTH-1:0]                  last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0]                  last_data_q, last_data_d;

  logic [IDX_W-1:0]       cur;
  logic [NUM_THREADS-1:0] pending_clr;
  logic                   reuse_hit;

  // Lowest set bit of pending is the thread being served; it stays stable
  // through WAIT_R because its pending bit only clears on completion.
  always_comb begin
    cur = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (pending_q[i]) cur = IDX_W'(i);
    end
  end

  assign pending_clr = pending_q & ~(NUM_THREADS'(1) << cur);
  assign reuse_hit   = !we_q && reuse_q && (addr_q[cur] == last_addr_q);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so that no
    // path through the case statement can leave one unassigned (no latches).
    state_d     = state_q;
    we_d        = we_q;
    mask_d      = mask_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    reuse_d     = reuse_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d      = req_we;
          mask_d    = req_mask;
          pending_d = req_mask;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          rdata_d   = '0;
          reuse_d   = 1'b0;
          state_d   = (req_mask == '0) ? RESP : ISSUE;
        end
      end

      ISSUE: begin
        if (reuse_hit) begin
          rdata_d[cur] = last_data_q;
          pending_d    = pending_clr;
          if (pending_clr == '0) state_d = RESP;
        end else begin
          // Driven purely from held state, so the access stays stable while stalled.
          mem_valid = 1'b1;
          mem_we    = we_q;
          mem_addr  = addr_q[cur];
          mem_wdata = wdata_q[cur];
          if (mem_ready) begin
            if (we_q) begin
              pending_d = pending_clr;
              if (pending_clr == '0) state_d = RESP;
            end else begin
              state_d = WAIT_R;
            end
          end
        end
      end

      WAIT_R: begin
        if (mem_rvalid) begin
          rdata_d[cur] = mem_rdata;
          last_addr_d  = addr_q[cur];
          last_data_d  = mem_rdata;
          reuse_d      = 1'b1;
          pending_d    = pending_clr;
          state_d      = (pending_clr == '0) ? RESP : ISSUE;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the request buffers are cleared on reset too; rsp_mask/rsp_rdata are
  // read straight from them and must show zeros right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      mask_q      <= '0;
      pending_q   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      reuse_q     <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      reuse_q     <= reuse_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  assign rsp_mask  = mask_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_warp_mem_sequencer.sv
// Scoreboard bench for warp_mem_sequencer: expected writes, reads and responses
// are queued when a request is driven and retired by a negedge memory/response monitor.
module tb_warp_mem_sequencer;

  typedef logic [3:0][15:0] vec_t;
  typedef struct {
    logic [3:0] mask;
    vec_t       rdata;
    int         lat;
  } rsp_exp_t;
  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_mask;
  vec_t        req_addr, req_wdata;
  logic        rsp_valid;
  logic [3:0]  rsp_mask;
  vec_t        rsp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        busy;

  rsp_exp_t    rsp_q[$];
  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int rd_k     = 1;
  int rd_cnt   = 0;
  logic [15:0] rd_addr = '0;

  warp_mem_sequencer #(.NUM_THREADS(4), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_mask(rsp_mask), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Memory responder plus write/read/response scoreboards, all at negedge.
  initial begin : monitor
    logic        p_stall;
    logic [15:0] p_addr, p_wd;
    logic        p_we;
    rsp_exp_t    e;
    wr_exp_t     w;
    logic [15:0] ra;
    p_stall = 1'b0; p_addr = '0; p_wd = '0; p_we = 1'b0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd_addr + 16'h100;
        end
      end
      if (p_stall) begin
        n_checks++;
        if (!(mem_valid && mem_addr == p_addr && mem_we == p_we && mem_wdata == p_wd))
          begin
          n_fail++;
          $display("FAIL mem_stable: got v=%b a=%h we=%b wd=%h expected v=1 a=%h we=%b wd=%h",
                   mem_valid, mem_addr, mem_we, mem_wdata, p_addr, p_we, p_wd);
        end
      end
      if (mem_valid && mem_ready) begin
        n_checks++;
        if (mem_we) begin
          if (wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got a=%h d=%h expected none", mem_addr, mem_wdata);
          end else begin
            w = wr_q.pop_front();
            if (mem_addr !== w.addr || mem_wdata !== w.data) begin
              n_fail++;
              $display("FAIL write: got a=%h d=%h expected a=%h d=%h",
                       mem_addr, mem_wdata, w.addr, w.data);
            end
          end
        end else begin
          if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: got a=%h expected none", mem_addr);
          end else begin
            ra = rd_q.pop_front();
            if (mem_addr !== ra) begin
              n_fail++;
              $display("FAIL read_addr: got %h expected %h", mem_addr, ra);
            end
          end
          rd_cnt  = rd_k;
          rd_addr = mem_addr;
        end
      end
      p_stall = mem_valid && !mem_ready;
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wd    = mem_wdata;
      if (rsp_valid) begin
        n_checks++;
        if (rsp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got mask=%b expected no response", rsp_mask);
        end else begin
          e = rsp_q.pop_front();
          if (rsp_mask !== e.mask || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL rsp_data: got mask=%b rdata=%h expected mask=%b rdata=%h",
                     rsp_mask, rsp_rdata, e.mask, e.rdata);
          end
          n_checks++;
          if (cyc - acc_cyc != e.lat) begin
            n_fail++;
            $display("FAIL rsp_latency: got %0d expected %0d", cyc - acc_cyc, e.lat);
          end
        end
      end
      if (req_valid && req_ready) acc_cyc = cyc;
    end
  end

  // Reference model: thread-order writes, reads skipped only when the address
  // repeats the most recent read, load data = addr + 0x100 from the responder.
  task automatic push_expect(input logic we, input logic [3:0] mask, input vec_t a,
                             input vec_t d, input int lat, input bit want_rsp);
    rsp_exp_t    e;
    wr_exp_t     w;
    logic        last_v;
    logic [15:0] last;
    e.mask  = mask;
    e.rdata = '0;
    e.lat   = lat;
    last_v  = 1'b0;
    last    = '0;
    for (int t = 0; t < 4; t++) begin
      if (mask[t]) begin
        if (we) begin
          w.addr = a[t];
          w.data = d[t];
          wr_q.push_back(w);
        end else begin
          if (!(last_v && a[t] == last)) begin
            rd_q.push_back(a[t]);
            last   = a[t];
            last_v = 1'b1;
          end
          e.rdata[t] = a[t] + 16'h100;
        end
      end
    end
    if (want_rsp) rsp_q.push_back(e);
  endtask

  // Returns one cycle after the accept edge (posedge + 1).
  task automatic drive_req(input logic we, input logic [3:0] mask, input vec_t a, input vec_t d);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_mask  = mask;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d responses outstanding expected 0", name, rsp_q.size());
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({req_ready, busy, rsp_valid, mem_valid, mem_we, mem_addr, mem_wdata, rsp_mask, rsp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b rv=%b mv=%b we=%b a=%h wd=%h m=%b rd=%h expected rdy=1 others 0",
               req_ready, busy, rsp_valid, mem_valid, mem_we, mem_addr, mem_wdata, rsp_mask, rsp_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_store;
    vec_t a, d;
    a = {16'h13, 16'h12, 16'h11, 16'h10};
    d = {16'hD, 16'hC, 16'hB, 16'hA};
    push_expect(1'b1, 4'b1011, a, d, 4, 1'b1);
    drive_req(1'b1, 4'b1011, a, d);
    wait_done("store");
    n_checks++;
    if (wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL store_writes: got %0d writes missing expected 0", wr_q.size());
    end
  endtask

  task automatic test_load;
    vec_t a, d, exp_rd;
    a = {16'h400C, 16'h3008, 16'h2004, 16'h1000};
    d = '0;
    exp_rd = {16'h410C, 16'h3108, 16'h2104, 16'h1100};
    push_expect(1'b0, 4'b1111, a, d, 9, 1'b1);
    drive_req(1'b0, 4'b1111, a, d);
    wait_done("load");
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_rdata !== exp_rd || rsp_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL load_hold: got mask=%b rdata=%h expected mask=1111 rdata=%h",
               rsp_mask, rsp_rdata, exp_rd);
    end
  endtask

  task automatic test_reuse;
    vec_t a, d;
    a = {16'h30, 16'h20, 16'h20, 16'h20};
    d = '0;
    push_expect(1'b0, 4'b1111, a, d, 7, 1'b1);
    drive_req(1'b0, 4'b1111, a, d);
    wait_done("reuse");
    n_checks++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL reuse_reads: got %0d reads missing expected 0", rd_q.size());
    end
  endtask

  task automatic test_stall;
    vec_t a, d;
    a = {16'h44, 16'h33, 16'h22, 16'h11};
    d = '0;
    mem_ready = 1'b0;
    push_expect(1'b0, 4'b0100, a, d, 6, 1'b1);
    drive_req(1'b0, 4'b0100, a, d);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (!(mem_valid === 1'b1 && mem_addr === 16'h33 && mem_we === 1'b0)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b a=%h expected v=1 a=0033", i, mem_valid, mem_addr);
      end
      if (i == 2) begin
        @(posedge clk); #1;
        mem_ready = 1'b1;
      end
    end
    wait_done("stall");
  endtask

  task automatic test_back_to_back;
    vec_t z, a2, d2;
    z  = '0;
    a2 = {16'h0, 16'h0, 16'h0, 16'h40};
    d2 = {16'h0, 16'h0, 16'h0, 16'h55};
    push_expect(1'b0, 4'b0000, z, z, 1, 1'b1);
    push_expect(1'b1, 4'b0001, a2, d2, 2, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_mask  = 4'b0000;
    req_addr  = z;
    req_wdata = z;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle_ready: got %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_we    = 1'b1;
    req_mask  = 4'b0001;
    req_addr  = a2;
    req_wdata = d2;
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, req_ready, mem_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_resp_cycle: got rv/rdy/mv=%b%b%b expected 100", rsp_valid, req_ready, mem_valid);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reaccept: got req_ready=%b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done("b2b");
  endtask

  task automatic test_reset_mid_op;
    vec_t a, d, a2;
    a  = {16'h0, 16'h0, 16'h0, 16'h77};
    d  = '0;
    a2 = {16'h0, 16'h0, 16'h51, 16'h50};
    rd_k = 6;
    push_expect(1'b0, 4'b0001, a, d, 0, 1'b0);
    drive_req(1'b0, 4'b0001, a, d);
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL midop_wait_state: got busy/mv=%b%b expected 10", busy, mem_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, busy, rsp_valid, mem_valid, mem_we, mem_addr, mem_wdata, rsp_mask, rsp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 64'h0}) begin
      n_fail++;
      $display("FAIL midop_reset_state: got rdy=%b busy=%b rv=%b mv=%b m=%b rd=%h expected rdy=1 others 0",
               req_ready, busy, rsp_valid, mem_valid, rsp_mask, rsp_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, req_ready, rsp_mask} !== {1'b0, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL midop_late_rvalid: got busy=%b rdy=%b mask=%b expected busy=0 rdy=1 mask=0000",
               busy, req_ready, rsp_mask);
    end
    rd_k = 1;
    push_expect(1'b0, 4'b0011, a2, d, 5, 1'b1);
    drive_req(1'b0, 4'b0011, a2, d);
    wait_done("post_reset");
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_mask   = '0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ready  = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    test_reset();
    test_store();
    test_load();
    test_reuse();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();

    repeat (3) @(posedge clk);
    n_checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0 || rsp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got wr=%0d rd=%0d rsp=%0d expected all 0",
               wr_q.size(), rd_q.size(), rsp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
